// File: rtl/uart_pkg.sv
// uart_pkg: types and line-level constants shared by the 8N1 receiver and transmitter.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP = 1'b1;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the RX pin plus a one-cycle falling-edge pulse.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic line_rx,
  output logic rx_s,
  output logic fall
);
  logic r_s1, r_s2, r_prev;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= LINE_IDLE;
      r_s2 <= LINE_IDLE;
      r_prev <= LINE_IDLE;
    end else begin
      r_s1 <= line_rx;
      r_s2 <= r_s1;
      r_prev <= r_s2;
    end
  end
  assign rx_s = r_s2;
  assign fall = r_prev & ~r_s2;
endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver sampling each bit at its centre, with valid and frame-error strobes.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote around the centre (one clock later).
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2500,
  localparam int HALF_BIT = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
  localparam int START_TICK = HALF_BIT;
`else
  localparam int START_TICK = HALF_BIT - 1;
`endif
  localparam logic [CW-1:0] START_END = CW'(START_TICK);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);
  rx_state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0] r_bit_idx, w_bit_idx_nx;
  logic [UART_DATA_BITS-1:0] r_shreg, w_shreg_nx, r_data, w_data_nx;
  logic r_valid, w_valid_nx, r_ferr, w_ferr_nx;
  logic w_rx_s, w_fall, w_bit;
  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .line_rx(line_rx),
    .rx_s   (w_rx_s),
    .fall   (w_fall)
  );
`ifdef UART_RX_MAJORITY_EN
  // r_h1/r_h2 hold the centre and centre-1 samples when the decision is taken at centre+1
  logic r_h1, r_h2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h1 <= LINE_IDLE;
      r_h2 <= LINE_IDLE;
    end else begin
      r_h1 <= w_rx_s;
      r_h2 <= r_h1;
    end
  end
  assign w_bit = maj3(r_h2, r_h1, w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_cnt + 1'b1;
    w_bit_idx_nx = r_bit_idx;
    w_shreg_nx = r_shreg;
    w_data_nx = r_data;
    w_valid_nx = 1'b0;
    w_ferr_nx = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        w_state_nx = w_fall ? START : IDLE;
      end
      START: if (r_cnt == START_END) begin
        w_cnt_nx = '0;
        w_bit_idx_nx = '0;
        w_state_nx = (w_bit == LINE_START) ? DATA : IDLE;
      end
      DATA: if (r_cnt == BIT_END) begin
        w_cnt_nx = '0;
        w_shreg_nx = {w_bit, r_shreg[UART_DATA_BITS-1:1]};
        w_bit_idx_nx = r_bit_idx + 1'b1;
        w_state_nx = (r_bit_idx == LAST_BIT) ? STOP : DATA;
      end
      STOP: if (r_cnt == BIT_END) begin
        w_cnt_nx = '0;
        w_state_nx = IDLE;
        w_valid_nx = (w_bit == LINE_STOP);
        w_ferr_nx = (w_bit != LINE_STOP);
        w_data_nx = (w_bit == LINE_STOP) ? r_shreg : r_data;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_bit_idx <= '0;
      r_shreg <= '0;
      r_data <= '0;
      r_valid <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_shreg <= w_shreg_nx;
      r_data <= w_data_nx;
      r_valid <= w_valid_nx;
      r_ferr <= w_ferr_nx;
    end
  end
  assign rx_data = r_data;
  assign rx_valid = r_valid;
  assign frame_err = r_ferr;
  assign busy = (r_state != IDLE);
endmodule
